// File: rtl/slot_fifo_arbiter.sv
// Round-robin arbiter sharing one slot-FIFO write port among NUM_SLOTS sources.
// Define SLOT_TAG_EN to prefix each message with a {4'hA,1'b0,grant} tag byte.
module slot_fifo_arbiter #(
  parameter int NUM_SLOTS  = 4,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 2048,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   fifo_clk,
  output logic [7:0]             fifo_data,
  output logic                   fifo_write,
  input  logic [AW-1:0]          fifo_addr_in,
  input  logic [AW-1:0]          fifo_addr_out,
  input  logic [NUM_SLOTS-1:0]   slot_enable,
  input  logic [NUM_SLOTS-1:0]   slot_req,
  input  logic [8*NUM_SLOTS-1:0] slot_data,
  output logic [NUM_SLOTS-1:0]   slot_ack,
  output logic [2:0]             grant,
  output logic                   busy,
  output logic [15:0]            stall_count
);

`ifdef SLOT_TAG_EN
  typedef enum logic [1:0] {IDLE, HDR, BURST} state_t;
  localparam int TAG_LEN = 1;
`else
  typedef enum logic [1:0] {IDLE, BURST} state_t;
  localparam int TAG_LEN = 0;
`endif

  localparam int NEED = BURST_LEN + TAG_LEN;
  localparam int CW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t               state, state_n;
  logic [CW-1:0]        byte_cnt;
  logic [AW-1:0]        fill, free;
  logic                 space_ok;
  logic [NUM_SLOTS-1:0] eligible;
  logic                 any_elig;
  logic [2:0]           sel;
  logic [7:0]           cur_byte;
  logic                 last_byte;

  assign fifo_clk  = clk;
  assign fill      = fifo_addr_in - fifo_addr_out;
  assign free      = AW'(FIFO_DEPTH - 1) - fill;
  assign space_ok  = (free >= AW'(NEED));
  assign eligible  = slot_req & slot_enable;
  assign any_elig  = |eligible;
  assign last_byte = (byte_cnt == CW'(BURST_LEN - 1));

  // Rotating search starting just after the last grant gives round-robin fairness.
  always_comb begin
    logic [7:0] elig8;
    logic [2:0] idx;
    logic       found;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel   = grant;
    found = 1'b0;
    idx   = '0;
    elig8 = 8'(eligible);
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      idx = 3'((int'(grant) + i) % NUM_SLOTS);
      if (!found && elig8[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (grant == 3'(k)) cur_byte = slot_data[8*k +: 8];
  end

  always_comb begin
    logic [7:0] ack8;
    state_n  = state;
    slot_ack = '0;
    ack8     = 8'd1 << grant;
    case (state)
      IDLE: if (any_elig && space_ok) begin
`ifdef SLOT_TAG_EN
        state_n = HDR;
`else
        state_n = BURST;
`endif
      end
`ifdef SLOT_TAG_EN
      HDR: state_n = BURST;
`endif
      BURST: begin
        slot_ack = ack8[NUM_SLOTS-1:0];
        if (last_byte) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 3'(NUM_SLOTS - 1);
      byte_cnt    <= '0;
      fifo_data   <= '0;
      fifo_write  <= 1'b0;
      busy        <= 1'b0;
      stall_count <= '0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != IDLE);
      fifo_write <= 1'b0;
      fifo_data  <= '0;
      case (state)
        IDLE: begin
          if (any_elig && space_ok) grant <= sel;
          else if (any_elig && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
`ifdef SLOT_TAG_EN
        HDR: begin
          fifo_write <= 1'b1;
          fifo_data  <= {4'hA, 1'b0, grant};
        end
`endif
        BURST: begin
          fifo_write <= 1'b1;
          fifo_data  <= cur_byte;
          byte_cnt   <= last_byte ? '0 : byte_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_fifo_arbiter.sv
// Scoreboard bench for slot_fifo_arbiter: modelled sources, expected FIFO bytes queued and
// compared as they are written. Tag-mode expectations follow SLOT_TAG_EN.
module tb_slot_fifo_arbiter;
  localparam int NS = 4;
  localparam int BL = 4;
`ifdef SLOT_TAG_EN
  localparam int TAG = 1;
`else
  localparam int TAG = 0;
`endif
  localparam int MSG    = BL + TAG;
  localparam int PERIOD = MSG + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_clk;
  logic [7:0]    fifo_data;
  logic          fifo_write;
  logic [10:0]   fifo_addr_in = '0;
  logic [10:0]   fifo_addr_out = '0;
  logic [NS-1:0] slot_enable = '0;
  logic [NS-1:0] slot_req = '0;
  logic [8*NS-1:0] slot_data;
  logic [NS-1:0] slot_ack;
  logic [2:0]    grant;
  logic          busy;
  logic [15:0]   stall_count;

  int vectors = 0;
  int miscompares = 0;
  logic       mon_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] src_mem[NS][64];
  logic [5:0] src_ptr[NS];
  logic [5:0] exp_ptr[NS];
  logic       src_clear = 1'b1;
  int         exp_stall = 0;

  slot_fifo_arbiter #(.NUM_SLOTS(NS), .BURST_LEN(BL), .FIFO_DEPTH(2048)) dut (
    .clk(clk), .reset(reset), .fifo_clk(fifo_clk), .fifo_data(fifo_data),
    .fifo_write(fifo_write), .fifo_addr_in(fifo_addr_in), .fifo_addr_out(fifo_addr_out),
    .slot_enable(slot_enable), .slot_req(slot_req), .slot_data(slot_data),
    .slot_ack(slot_ack), .grant(grant), .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Source model: presents its current byte and advances on every acked edge.
  for (genvar g = 0; g < NS; g++) begin : g_src
    assign slot_data[8*g +: 8] = src_mem[g][src_ptr[g]];
    always @(posedge clk) begin
      if (src_clear) src_ptr[g] <= '0;
      else if (slot_ack[g]) src_ptr[g] <= src_ptr[g] + 6'd1;
    end
  end

  // Scoreboard: each write pops one expected byte; idle cycles must carry data 0.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (fifo_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got byte %h, expected no write", fifo_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (fifo_data !== e) begin
            miscompares++;
            $display("FAIL fifo_byte: got %h, expected %h", fifo_data, e);
          end
        end
      end else if (fifo_write !== 1'b0 || fifo_data !== 8'h00) begin
        miscompares++;
        $display("FAIL idle_cycle: got write=%b data=%h, expected write=0 data=00", fifo_write, fifo_data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_burst(input int s);
`ifdef SLOT_TAG_EN
    exp_q.push_back({4'hA, 1'b0, 3'(s)});
`endif
    for (int b = 0; b < BL; b++) begin
      exp_q.push_back(src_mem[s][exp_ptr[s]]);
      exp_ptr[s] = exp_ptr[s] + 6'd1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_clear = 1'b1;
    slot_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    src_clear = 1'b0;
    for (int s = 0; s < NS; s++) exp_ptr[s] = '0;
    exp_stall = 0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (PERIOD + 2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d bytes never written, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Holds req for n bursts, checking grant order and one-hot ack per burst.
  task automatic run_bursts(input logic [NS-1:0] en, input logic [NS-1:0] req, input int n,
                            input int order[8], output logic [NS-1:0] acc);
    slot_enable = en;
    for (int j = 0; j < n; j++) push_burst(order[j]);
    acc = '0;
    slot_req = req;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < PERIOD; k++) begin
        @(negedge clk);
        acc |= slot_ack;
        if (k == 0) begin
          vectors++;
          if (grant !== 3'(order[j])) begin
            miscompares++;
            $display("FAIL rr_grant[%0d]: got %0d, expected %0d", j, grant, order[j]);
          end
        end
        if (k == TAG) begin
          vectors++;
          if (slot_ack !== NS'(1 << order[j])) begin
            miscompares++;
            $display("FAIL rr_ack[%0d]: got %b, expected %b", j, slot_ack, NS'(1 << order[j]));
          end
        end
      end
    end
    slot_req = '0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 6;
    if (fifo_write !== 1'b0) begin miscompares++; $display("FAIL rst_write: got %b, expected 0", fifo_write); end
    if (fifo_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h, expected 00", fifo_data); end
    if (slot_ack !== '0) begin miscompares++; $display("FAIL rst_ack: got %b, expected 0", slot_ack); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    if (grant !== 3'(NS - 1)) begin miscompares++; $display("FAIL rst_grant: got %0d, expected %0d", grant, NS - 1); end
    if (stall_count !== 16'd0) begin miscompares++; $display("FAIL rst_stall: got %0d, expected 0", stall_count); end
  endtask

  task automatic test_single();
    logic [31:0] got, want;
    do_reset();
    slot_enable = 4'b0001;
    fifo_addr_in = '0;
    fifo_addr_out = '0;
    repeat (3) push_burst(0);
    got = '0;
    want = '0;
    slot_req = 4'b0001;
    for (int i = 1; i <= 2 * PERIOD + 1; i++) begin
      @(negedge clk);
      got[i] = fifo_write;
      want[i] = ((i - 1) % PERIOD) != 0;
      if (i == 1) begin
        vectors += 2;
        if (grant !== 3'd0) begin miscompares++; $display("FAIL single_grant: got %0d, expected 0", grant); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b, expected 1", busy); end
      end
    end
    slot_req = '0;
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL single_write_pattern: got %b, expected %b", got, want);
    end
    drain("single");
  endtask

  task automatic test_round_robin();
    logic [NS-1:0] acc;
    do_reset();
    fifo_addr_in = '0;
    fifo_addr_out = '0;
    run_bursts(4'hF, 4'hF, 8, '{0, 1, 2, 3, 0, 1, 2, 3}, acc);
    vectors++;
    if (acc !== 4'hF) begin miscompares++; $display("FAIL rr_ack_union: got %b, expected 1111", acc); end
    drain("round_robin");
  endtask

  task automatic test_stall();
    do_reset();
    slot_enable = 4'hF;
    fifo_addr_in = 11'h7FD;
    fifo_addr_out = 11'h000;
    slot_req = 4'b0010;
    repeat (10) @(negedge clk);
    exp_stall = 10;
    vectors += 2;
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL stall_count: got %0d, expected %0d", stall_count, exp_stall); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_busy: got %b, expected 0", busy); end
`ifdef SLOT_TAG_EN
    fifo_addr_out = 11'h002;
    repeat (3) @(negedge clk);
    exp_stall = 13;
    vectors += 2;
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL stall_need5: got %0d, expected %0d", stall_count, exp_stall); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_need5_busy: got %b, expected 0", busy); end
    fifo_addr_out = 11'h003;
`else
    fifo_addr_out = 11'h002;
`endif
    push_burst(1);
    @(negedge clk);
    vectors += 3;
    if (grant !== 3'd1) begin miscompares++; $display("FAIL stall_release_grant: got %0d, expected 1", grant); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_release_busy: got %b, expected 1", busy); end
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL stall_hold: got %0d, expected %0d", stall_count, exp_stall); end
    slot_req = '0;
    drain("stall");
  endtask

  task automatic test_wrap();
    fifo_addr_in = 11'h001;
    fifo_addr_out = 11'h7FF;
    slot_enable = 4'hF;
    push_burst(2);
    slot_req = 4'b0100;
    @(negedge clk);
    vectors += 2;
    if (grant !== 3'd2) begin miscompares++; $display("FAIL wrap_grant: got %0d, expected 2", grant); end
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL wrap_stall: got %0d, expected %0d", stall_count, exp_stall); end
    slot_req = '0;
    drain("wrap");
  endtask

  task automatic test_enable_mask();
    logic [NS-1:0] acc;
    do_reset();
    fifo_addr_in = '0;
    fifo_addr_out = '0;
    run_bursts(4'b1011, 4'hF, 6, '{0, 1, 3, 0, 1, 3, 0, 0}, acc);
    vectors++;
    if (acc !== 4'b1011) begin miscompares++; $display("FAIL mask_ack_union: got %b, expected 1011", acc); end
    drain("enable_mask");
  endtask

  task automatic test_reset_mid();
    do_reset();
    slot_enable = 4'hF;
    fifo_addr_in = '0;
    fifo_addr_out = '0;
`ifdef SLOT_TAG_EN
    exp_q.push_back(8'hA1);
`endif
    exp_q.push_back(src_mem[1][0]);
    slot_req = 4'b0010;
    repeat (2 + TAG) @(negedge clk);
    reset = 1'b1;
    src_clear = 1'b1;
    slot_req = '0;
    @(negedge clk);
    vectors += 4;
    if (fifo_write !== 1'b0) begin miscompares++; $display("FAIL midrst_write: got %b, expected 0", fifo_write); end
    if (slot_ack !== '0) begin miscompares++; $display("FAIL midrst_ack: got %b, expected 0", slot_ack); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    if (grant !== 3'(NS - 1)) begin miscompares++; $display("FAIL midrst_grant: got %0d, expected %0d", grant, NS - 1); end
    reset = 1'b0;
    src_clear = 1'b0;
    for (int s = 0; s < NS; s++) exp_ptr[s] = '0;
    push_burst(0);
    push_burst(1);
    slot_req = 4'b0011;
    @(negedge clk);
    vectors++;
    if (grant !== 3'd0) begin miscompares++; $display("FAIL midrst_next_grant: got %0d, expected 0", grant); end
    repeat (PERIOD) @(negedge clk);
    vectors++;
    if (grant !== 3'd1) begin miscompares++; $display("FAIL midrst_second_grant: got %0d, expected 1", grant); end
    slot_req = '0;
    drain("reset_mid");
  endtask

`ifdef SLOT_TAG_EN
  task automatic test_tag();
    do_reset();
    slot_enable = 4'hF;
    fifo_addr_in = '0;
    fifo_addr_out = '0;
    push_burst(3);
    slot_req = 4'b1000;
    @(negedge clk);
    vectors += 3;
    if (grant !== 3'd3) begin miscompares++; $display("FAIL tag_grant: got %0d, expected 3", grant); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL tag_busy: got %b, expected 1", busy); end
    if (slot_ack !== '0) begin miscompares++; $display("FAIL tag_hdr_ack: got %b, expected 0", slot_ack); end
    slot_req = '0;
    drain("tag");
  endtask
`endif

  initial begin
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < 64; n++)
        src_mem[s][n] = 8'((s << 6) | n);
    src_mem[0][0] = 8'hEF;
    src_mem[0][1] = 8'hBE;
    src_mem[0][2] = 8'hAD;
    src_mem[0][3] = 8'hDE;
    do_reset();
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_enable_mask();
    test_reset_mid();
`ifdef SLOT_TAG_EN
    test_tag();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
